sodor5_instr_gen: RTL and testbench

SODOR5_INSTR_GEN -- requirements
Module: sodor5_instr_gen

---
 rtl/sodor5_gen_pkg.sv | 25 ++
 rtl/sodor5_lfsr32.sv | 28 ++
 rtl/sodor5_instr_gen.sv | 102 ++++++++++
 tb/tb_sodor5_instr_gen.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/sodor5_gen_pkg.sv
// rtl/sodor5_gen_pkg.sv - shared constants and FSM state type for the instruction generator
package sodor5_gen_pkg;

   localparam logic [6:0]  OP_ALU    = 7'h13;
   localparam logic [6:0]  OP_LOAD   = 7'h03;
   localparam logic [31:0] INSTR_NOP = 32'h00000013;
   localparam logic [31:0] LFSR_POLY = 32'h80200003;

   // Shift immediates: srai/srli keep shamt plus the arithmetic bit, slli keeps shamt only
   localparam logic [11:0] MASK_SR   = 12'h41F;
   localparam logic [11:0] MASK_SL   = 12'h01F;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GEN_A = 2'd1,
      ST_GEN_B = 2'd2,
      ST_VALID = 2'd3
   } gen_state_e;

   // An all-zero Galois LFSR locks up, so zero seeds are replaced by 1
   function automatic logic [31:0] nonzero_seed(input logic [31:0] s);
      return (s == 32'h0) ? 32'h00000001 : s;
   endfunction

endpackage

// File: rtl/sodor5_lfsr32.sv
// rtl/sodor5_lfsr32.sv - 32-bit Galois LFSR with seed load and zero substitution
module sodor5_lfsr32
   import sodor5_gen_pkg::*;
#(
   parameter logic [31:0] SEED = 32'h00000166
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] load_val,
   input  logic        step,
   output logic [31:0] state,
   output logic [31:0] next_val
);

   assign next_val = {1'b0, state[31:1]} ^ (state[0] ? LFSR_POLY : 32'h0);

   // Reset beats load, load beats stepping
   always_ff @(posedge clk) begin
      if (reset)
         state <= nonzero_seed(SEED);
      else if (load)
         state <= nonzero_seed(load_val);
      else if (step)
         state <= next_val;
   end

endmodule

// File: rtl/sodor5_instr_gen.sv
// rtl/sodor5_instr_gen.sv - random RV32I ALU-immediate / load instruction generator
module sodor5_instr_gen
   import sodor5_gen_pkg::*;
#(
   parameter logic [31:0] SEED    = 32'h00000166,
   parameter int unsigned LOAD_EN = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        seed_load,
   input  logic [31:0] seed_val,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_count,
   output logic [31:0] lfsr_state
);

   gen_state_e  state, state_nxt;
   logic        step;
   logic        handshake;
   logic [31:0] lfsr_next;
   logic [31:0] word_a, word_b;
   logic [11:0] imm;
   logic [4:0]  rs1, rd;
   logic [2:0]  funct3;
   logic        il_choice;
   logic        unused_bits;

   sodor5_lfsr32 #(.SEED(SEED)) u_lfsr (
      .clk      (clk),
      .reset    (reset),
      .load     (seed_load),
      .load_val (seed_val),
      .step     (step),
      .state    (lfsr_state),
      .next_val (lfsr_next)
   );

   assign out_valid = (state == ST_VALID);
   assign handshake = out_valid && out_ready;

   // Next-state: enable only matters for starting a new instruction; seed_load aborts everything
   always_comb begin
      state_nxt = state;
      step      = 1'b0;
      case (state)
         ST_IDLE:  if (enable) state_nxt = ST_GEN_A;
         ST_GEN_A: begin step = 1'b1; state_nxt = ST_GEN_B; end
         ST_GEN_B: begin step = 1'b1; state_nxt = ST_VALID; end
         ST_VALID: if (handshake) state_nxt = enable ? ST_GEN_A : ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
      if (seed_load) begin
         state_nxt = ST_IDLE;
         step      = 1'b0;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Capture the freshly stepped LFSR value as word A then word B
   always_ff @(posedge clk) begin
      if (reset) begin
         word_a <= 32'h0;
         word_b <= 32'h0;
      end else if (!seed_load) begin
         if (state == ST_GEN_A) word_a <= lfsr_next;
         if (state == ST_GEN_B) word_b <= lfsr_next;
      end
   end

   // Handshakes are counted even when a seed_load discards the generator in the same cycle
   always_ff @(posedge clk) begin
      if (reset)          instr_count <= 32'h0;
      else if (handshake) instr_count <= instr_count + 32'h1;
   end

   // Decode the captured words into the instruction; words are frozen in VALID so instr is stable
   always_comb begin
      imm       = word_a[11:0];
      rs1       = word_a[16:12];
      rd        = word_a[21:17];
      funct3    = word_a[24:22];
      il_choice = (LOAD_EN == 0) ? 1'b1 : word_a[25];
      if (funct3 == 3'd5)      imm = imm & MASK_SR;
      else if (funct3 == 3'd1) imm = imm & MASK_SL;
      instr = INSTR_NOP;
      if (out_valid) begin
         if (il_choice) instr = {imm, rs1, funct3, rd, OP_ALU};
         else           instr = {word_b[11:0], rs1, word_b[14], 2'b00, rd, OP_LOAD};
      end
   end

   assign unused_bits = ^{word_a[31:26], word_b[31:15], word_b[13:12]};

endmodule

// File: tb/tb_sodor5_instr_gen.sv
// tb/tb_sodor5_instr_gen.sv - self-checking bench for sodor5_instr_gen
module tb_sodor5_instr_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable, seed_load, out_ready;
   logic [31:0] seed_val;
   logic        out_valid;
   logic [31:0] instr, instr_count, lfsr_state;

   logic        en0, sl0, rdy0;
   logic [31:0] sv0;
   logic        ov0;
   logic [31:0] instr0, cnt0, lfsr0;

   int unsigned checks   = 0;
   int unsigned failures = 0;
   logic [31:0] m, m0, exp_cnt, exp_cnt0;

   always #5 clk = ~clk;

   sodor5_instr_gen dut (
      .clk(clk), .reset(reset), .enable(enable), .seed_load(seed_load),
      .seed_val(seed_val), .out_ready(out_ready), .out_valid(out_valid),
      .instr(instr), .instr_count(instr_count), .lfsr_state(lfsr_state)
   );

   sodor5_instr_gen #(.LOAD_EN(0)) dut0 (
      .clk(clk), .reset(reset), .enable(en0), .seed_load(sl0),
      .seed_val(sv0), .out_ready(rdy0), .out_valid(ov0),
      .instr(instr0), .instr_count(cnt0), .lfsr_state(lfsr0)
   );

   function automatic logic [31:0] lstep(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
   endfunction

   // Expected instruction produced from LFSR value s (two steps: word A then word B)
   function automatic logic [31:0] model_instr(input logic [31:0] s, input bit load_en);
      logic [31:0] a, b;
      logic [11:0] im;
      a  = lstep(s);
      b  = lstep(a);
      im = a[11:0];
      if (a[24:22] == 3'd5)      im = im & 12'h41F;
      else if (a[24:22] == 3'd1) im = im & 12'h01F;
      if (a[25] || !load_en)
         return {im, a[16:12], a[24:22], a[21:17], 7'h13};
      return {b[11:0], a[16:12], b[14], 2'b00, a[21:17], 7'h03};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!out_valid && n < 20) begin
         tick();
         n++;
      end
      chk(tag, {31'b0, out_valid}, 32'h1);
   endtask

   task automatic dut0_cycle();
      if (ov0 && rdy0) begin
         chk("ld0_instr", instr0, model_instr(m0, 1'b0));
         chk("ld0_opcode", {25'b0, instr0[6:0]}, 32'h13);
         m0 = lstep(lstep(m0));
         exp_cnt0++;
      end
      if (!ov0) chk("ld0_nop", instr0, 32'h00000013);
      tick();
      chk("ld0_count", cnt0, exp_cnt0);
   endtask

   initial begin
      int unsigned n_acc, cyc;
      logic [6:0]  op;
      logic [2:0]  f3;

      reset = 1'b1; enable = 1'b1; seed_load = 1'b0; seed_val = 32'h0; out_ready = 1'b0;
      en0 = 1'b0; sl0 = 1'b0; sv0 = 32'h0; rdy0 = 1'b0;
      repeat (5) tick();
      chk("rst_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_instr", instr, 32'h00000013);
      chk("rst_count", instr_count, 32'h0);
      chk("rst_lfsr", lfsr_state, 32'h00000166);
      chk("rst_valid0", {31'b0, ov0}, 32'h0);

      // Zero seed
      reset = 1'b0; enable = 1'b0; seed_load = 1'b1; seed_val = 32'h0;
      tick();
      seed_load = 1'b0;
      chk("zseed_lfsr", lfsr_state, 32'h00000001);
      chk("zseed_valid", {31'b0, out_valid}, 32'h0);
      enable = 1'b1;
      tick();
      tick();
      chk("zseed_word_a", lfsr_state, 32'h80200003);
      tick();
      chk("zseed_word_b", lfsr_state, 32'hC0300002);
      chk("zseed_valid1", {31'b0, out_valid}, 32'h1);
      chk("zseed_instr", instr, 32'h00200803);
      chk("zseed_model", instr, model_instr(32'h1, 1'b1));

      // Backpressure
      repeat (10) begin
         tick();
         chk("bp_instr", instr, 32'h00200803);
         chk("bp_valid", {31'b0, out_valid}, 32'h1);
         chk("bp_count", instr_count, 32'h0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_count1", instr_count, 32'h1);
      chk("bp_valid0", {31'b0, out_valid}, 32'h0);

      // seed_load in VALID without handshake
      m = 32'hC0300002;
      wait_valid("sl_wait");
      chk("sl_pre_instr", instr, model_instr(m, 1'b1));
      seed_load = 1'b1; seed_val = 32'h1234ABCD;
      tick();
      seed_load = 1'b0;
      chk("sl_valid", {31'b0, out_valid}, 32'h0);
      chk("sl_count", instr_count, 32'h1);
      chk("sl_lfsr", lfsr_state, 32'h1234ABCD);

      // seed_load coinciding with a handshake still counts it
      m = 32'h1234ABCD;
      wait_valid("slhs_wait");
      chk("slhs_instr", instr, model_instr(m, 1'b1));
      out_ready = 1'b1; seed_load = 1'b1; seed_val = 32'hDEADBEEF;
      tick();
      out_ready = 1'b0; seed_load = 1'b0;
      chk("slhs_count", instr_count, 32'h2);
      chk("slhs_valid", {31'b0, out_valid}, 32'h0);
      chk("slhs_lfsr", lfsr_state, 32'hDEADBEEF);

      // Random run
      m = 32'hDEADBEEF; exp_cnt = 32'h2; n_acc = 0; cyc = 0;
      while (n_acc < 1000 && cyc < 20000) begin
         enable    = ($urandom % 8) != 0;
         out_ready = ($urandom % 3) != 0;
         if (out_valid && out_ready) begin
            op = instr[6:0];
            f3 = instr[14:12];
            chk("rnd_instr", instr, model_instr(m, 1'b1));
            chk("rnd_opcode", {31'b0, (op == 7'h13) || (op == 7'h03)}, 32'h1);
            if (op == 7'h03) chk("rnd_ld_f3", {31'b0, (f3 == 3'd0) || (f3 == 3'd4)}, 32'h1);
            if (op == 7'h13 && f3 == 3'd1) chk("rnd_slli", {25'b0, instr[31:25]}, 32'h0);
            if (op == 7'h13 && f3 == 3'd5)
               chk("rnd_sr", {31'b0, instr[31] == 1'b0 && instr[29:25] == 5'd0}, 32'h1);
            m = lstep(lstep(m));
            exp_cnt++;
            n_acc++;
         end
         if (!out_valid) chk("rnd_nop", instr, 32'h00000013);
         tick();
         cyc++;
         chk("rnd_count", instr_count, exp_cnt);
      end
      chk("rnd_done", n_acc, 32'd1000);

      // Reset mid-instruction wins over seed_load
      enable = 1'b1; out_ready = 1'b0;
      tick();
      reset = 1'b1; seed_load = 1'b1; seed_val = 32'h5;
      tick();
      reset = 1'b0; seed_load = 1'b0; enable = 1'b0;
      chk("rst2_lfsr", lfsr_state, 32'h00000166);
      chk("rst2_count", instr_count, 32'h0);
      chk("rst2_valid", {31'b0, out_valid}, 32'h0);
      chk("rst2_instr", instr, 32'h00000013);

      // LOAD_EN=0 instance with enable toggling
      m0 = 32'h00000166; exp_cnt0 = 32'h0;
      repeat (400) begin
         en0  = $urandom % 2;
         rdy0 = $urandom % 2;
         dut0_cycle();
      end
      en0 = 1'b0; rdy0 = 1'b1;
      repeat (6) dut0_cycle();
      rdy0 = 1'b0;
      repeat (10) begin
         tick();
         chk("ld0_idle_valid", {31'b0, ov0}, 32'h0);
      end
      chk("ld0_some", {31'b0, exp_cnt0 > 32'd20}, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
